// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: decode-stage sequencer holding one instruction between fetch and EX.
// Optional performance counters are built when DECODE_ISSUE_PERF_EN is defined.
module decode_issue_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect,
  output logic        stall
`ifdef DECODE_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush
`endif
);

  // Opcode values from Opcode.vh (RV32I major opcodes)
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [CNT_W-1:0] LAT      = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ld_cnt;
  logic [4:0]       ld_rd;

  logic [6:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       issue;
  logic       accept;

  assign opc = id_instr[6:0];
  assign rd  = id_instr[11:7];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: use_rs1 = 1'b0;
      default: ;
    endcase
    case (opc)
      OPC_BRANCH, OPC_STORE, OPC_ARI_RTYPE: use_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = (ld_cnt != CNT_ZERO) && (ld_rd != 5'd0) &&
                  ((use_rs1 && (rs1 == ld_rd)) || (use_rs2 && (rs2 == ld_rd)));

  // Issue decision is purely combinational so a held instruction leaves with no added latency.
  assign ex_valid = (state == HOLD) && !hazard && !redirect;
  assign issue    = ex_valid && ex_ready;
  assign if_ready = !redirect && ((state == EMPTY) || issue);
  assign accept   = if_valid && if_ready;
  assign stall    = (state == STALL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      id_instr <= NOP;
      id_pc    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            id_instr <= if_instr;
            id_pc    <= if_pc;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            id_instr <= NOP;
            id_pc    <= '0;
            state    <= EMPTY;
          end else if (hazard) begin
            state <= STALL;
          end else if (issue) begin
            if (accept) begin
              id_instr <= if_instr;
              id_pc    <= if_pc;
            end else begin
              state <= EMPTY;
            end
          end
        end
        STALL: begin
          if (redirect) begin
            id_instr <= NOP;
            id_pc    <= '0;
            state    <= EMPTY;
          end else if (!hazard) begin
            state <= HOLD;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // The tracker survives redirects: the load is older than the branch that squashed us.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt <= CNT_ZERO;
      ld_rd  <= 5'd0;
    end else if (issue && (opc == OPC_LOAD) && (rd != 5'd0)) begin
      ld_rd  <= rd;
      ld_cnt <= LAT;
    end else if (ex_ready && (ld_cnt != CNT_ZERO)) begin
      ld_cnt <= ld_cnt - CNT_ONE;
    end
  end

`ifdef DECODE_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_flush     <= '0;
    end else begin
      if (state == STALL) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (redirect && (state != EMPTY)) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed plus randomized checks of decode_issue_ctrl against a
// cycle-level behavioural model of the issue rules.
module tb_decode_issue_ctrl;

  localparam int          LOAD_LAT = 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_ITYPE  = 7'b0010011;
  localparam logic [6:0] O_RTYPE  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect;
  logic        stall;
`ifdef DECODE_ISSUE_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush;
`endif

  decode_issue_ctrl #(.LOAD_LAT(LOAD_LAT), .CNT_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_ready (if_ready),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .redirect (redirect),
    .stall    (stall)
`ifdef DECODE_ISSUE_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: an occupied slot, a "waiting out a bubble" flag, and a load scoreboard.
  bit          m_full;
  bit          m_wait;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  int          m_ld_rd;
  int          m_ld_cnt;
  int          m_flush;
  int          m_stall_cyc;
  int          cyc;
  int          stall_seen;
  logic [31:0] issue_pc[$];
  int          issue_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == O_LUI || op == O_AUIPC || op == O_JAL);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == O_BRANCH || op == O_STORE || op == O_RTYPE);
  endfunction

  function automatic bit model_hazard();
    int r1;
    int r2;
    r1 = int'(m_instr[19:15]);
    r2 = int'(m_instr[24:20]);
    if (m_ld_cnt == 0 || m_ld_rd == 0) return 1'b0;
    return (reads_rs1(m_instr[6:0]) && r1 == m_ld_rd) ||
           (reads_rs2(m_instr[6:0]) && r2 == m_ld_rd);
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int rs1, input int imm);
    logic [31:0] w;
    w = {12'(imm), 5'(rs1), 3'b000, 5'(rd), op};
    return w;
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), O_RTYPE};
    return w;
  endfunction

  task automatic model_reset();
    m_full = 0; m_wait = 0; m_instr = NOP; m_pc = '0;
    m_ld_rd = 0; m_ld_cnt = 0; m_flush = 0; m_stall_cyc = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; if_valid = 0; if_instr = '0; if_pc = '0; ex_ready = 0; redirect = 0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_if_ready", if_ready, 1);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // One clock: drive at negedge, compare #1 later, advance model at posedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit er, input bit rdr, output bit accepted);
    bit haz, exv, iss, ifr, stl;
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = er; redirect = rdr;
    #1;
    haz = m_full && !m_wait && model_hazard();
    exv = m_full && !m_wait && !haz && !rdr;
    iss = exv && er;
    ifr = !rdr && (!m_full || iss);
    stl = m_full && m_wait;
    check("ex_valid", ex_valid, exv);
    check("if_ready", if_ready, ifr);
    check("stall", stall, stl);
    if (m_full) begin
      check("id_instr", id_instr, m_instr);
      check("id_pc", id_pc, m_pc);
    end
`ifdef DECODE_ISSUE_PERF_EN
    check("perf_stall_cyc", perf_stall_cyc, m_stall_cyc);
    check("perf_flush", perf_flush, m_flush);
`endif
    accepted = v && ifr;
    if (iss) begin issue_pc.push_back(m_pc); issue_cyc.push_back(cyc); end
    if (stl) begin stall_seen++; m_stall_cyc++; end
    if (m_full && m_wait) haz = model_hazard();
    @(posedge clk);
    if (iss && m_instr[6:0] == O_LOAD && m_instr[11:7] != 0) begin
      m_ld_rd = int'(m_instr[11:7]);
      m_ld_cnt = LOAD_LAT;
    end else if (er && m_ld_cnt > 0) begin
      m_ld_cnt--;
    end
    if (rdr) begin
      if (m_full) m_flush++;
      m_full = 0; m_wait = 0; m_instr = NOP; m_pc = '0;
    end else if (!m_full) begin
      if (v) begin m_full = 1; m_instr = ins; m_pc = pc; end
    end else if (m_wait) begin
      if (!haz) m_wait = 0;
    end else if (haz) begin
      m_wait = 1;
    end else if (iss) begin
      if (v) begin m_instr = ins; m_pc = pc; end
      else m_full = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_prog(input logic [31:0] prog[$], input logic [31:0] base);
    int p = 0;
    int budget = 50;
    bit acc;
    while ((p < prog.size() || m_full) && budget > 0) begin
      if (p < prog.size()) step(1, prog[p], base + 32'(4 * p), 1, 0, acc);
      else step(0, NOP, '0, 1, 0, acc);
      if (acc) p++;
      budget--;
    end
    check("drain_timeout", 32'(budget == 0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [6:0]  pool[9];
    int          c0;
    int          s0;
    bit          acc;

    pool = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BRANCH, O_LOAD, O_STORE, O_ITYPE, O_RTYPE};
    cyc = 0; stall_seen = 0;
    model_reset();
    rst = 1'b1;
    apply_reset();
    step(0, NOP, '0, 1, 0, acc);
    check("idle_id_instr", id_instr, NOP);

    // Back-to-back ADDI stream
    issue_pc.delete(); issue_cyc.delete();
    prog = '{enc_i(O_ITYPE, 1, 0, 1), enc_i(O_ITYPE, 2, 0, 2),
             enc_i(O_ITYPE, 3, 0, 3), enc_i(O_ITYPE, 4, 0, 4)};
    c0 = cyc;
    run_prog(prog, 32'h0);
    check("stream_issues", issue_pc.size(), 4);
    if (issue_pc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("stream_pc", issue_pc[i], 32'(4 * i));
        check("stream_cycle", issue_cyc[i], c0 + 1 + i);
      end
    end

    // Load-use: dependent ADD must see a single stall cycle
    issue_pc.delete(); s0 = stall_seen;
    prog = '{enc_i(O_LOAD, 5, 0, 0), enc_r(6, 5, 7)};
    run_prog(prog, 32'h40);
    check("ldu_stall_once", stall_seen - s0, 1);
    check("ldu_issues", issue_pc.size(), 2);

    // Load to x0 never blocks
    s0 = stall_seen;
    prog = '{enc_i(O_LOAD, 0, 0, 0), enc_r(6, 0, 0)};
    run_prog(prog, 32'h80);
    check("ld_x0_no_stall", stall_seen - s0, 0);

    // LUI reads no source register
    s0 = stall_seen;
    prog = '{enc_i(O_LOAD, 5, 0, 0), {20'h00001, 5'd5, O_LUI}};
    run_prog(prog, 32'hC0);
    check("lui_no_stall", stall_seen - s0, 0);

    // EX back-pressure: ID must hold steady
    issue_pc.delete();
    step(1, enc_i(O_ITYPE, 9, 0, 9), 32'h100, 0, 0, acc);
    held_instr = id_instr; held_pc = id_pc;
    check("bp_loaded", held_pc, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step(1, enc_i(O_ITYPE, 10, 0, i), 32'h104, 0, 0, acc);
      check("bp_instr_stable", id_instr, held_instr);
      check("bp_pc_stable", id_pc, held_pc);
    end
    check("bp_no_issue", issue_pc.size(), 0);
    run_prog('{}, 32'h0);
    check("bp_issued_after", issue_pc.size(), 1);

    // Redirect while holding, with fetch offering the next instruction
    issue_pc.delete();
    step(1, enc_i(O_ITYPE, 11, 0, 1), 32'h200, 0, 0, acc);
    step(1, enc_i(O_ITYPE, 12, 0, 2), 32'h204, 1, 1, acc);
    check("redir_no_accept", 32'(acc), 0);
    step(0, NOP, '0, 1, 0, acc);
    check("redir_empty_ready", if_ready, 1);
    check("redir_no_issue", issue_pc.size(), 0);
`ifdef DECODE_ISSUE_PERF_EN
    check("redir_perf_flush", perf_flush, 1);
`endif

    // Randomized traffic with a mid-run reset
    for (int k = 0; k < 400; k++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0]   = pool[$urandom_range(0, 8)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      if (k == 200) apply_reset();
      step($urandom_range(0, 3) != 0, w, 32'(4 * k), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
